uart_tx_top: RTL and testbench
==============================

// Module: uart_tx_top
// PURPOSE
//   16550-style UART transmitter. Pulls characters from the TX FIFO, serialises
//   them LSB-first on tx as start / 5-8 data / optional parity / 1, 1.5 or 2
//   stop bits. Bit timing uses the shared 16x baud_pulse tick. It is the
//   transmit counterpart of uart_rx_top and uses the same LCR field encodings.
// PARAMETERS
//   OVS   16   baud_pulse ticks per bit (1.5 stop = OVS*3/2 ticks)
// PORTS
//   clk            in   1  system clock
//   rst_n          in   1  asynchronous active-low reset
//   baud_pulse     in   1  1-clk-wide 16x oversample tick
//   wls            in   2  word length: 00=5,01=6,10=7,11=8 data bits
//   stb            in   1  0=1 stop; 1=2 stop (1.5 when wls=00)
//   pen            in   1  parity enable
//   eps            in   1  even parity select
//   sticky_parity  in   1  stick parity
//   set_break      in   1  force tx low (LCR[6])
//   fifo_empty     in   1  TX FIFO empty
//   din            in   8  TX FIFO head word (first-word-fall-through)
//   pop            out  1  1-clk pop strobe to TX FIFO
//   tx             out  1  serial output, idle = 1
//   sreg_empty     out  1  shifter idle, no frame in progress (TEMT)
// BEHAVIOUR
//   Reset (async, rst_n=0): tx=1, pop=0, sreg_empty=1, state=IDLE, counters=0.
//     Reset mid-frame aborts the frame; tx returns to 1 immediately.
//   The FSM and counters advance only in clk cycles with baud_pulse=1.
//     tx is registered and changes 1 clk after the qualifying baud_pulse.
//   States: IDLE, START, DATA, PARITY, STOP.
//   IDLE: on baud_pulse with fifo_empty=0:
//     - pop=1 for exactly that clk; latch din into shift reg.
//     - latch wls/pen/eps/sticky_parity/stb (frame config is frozen).
//     - go to START, tx=0, sreg_empty=0.
//   With fifo_empty=1, stay in IDLE with tx=1.
//   START: hold tx=0 for OVS ticks, then go to DATA and drive bit0.
//   DATA: each bit is held for OVS ticks, LSB first. wls+5 bits are sent;
//     din bits above the word length are ignored.
//   After the last data bit: go to PARITY if pen=1, else go to STOP.
//   PARITY: hold the bit for OVS ticks. {sticky_parity,eps} selects:
//     00 odd  = ~^data
//     01 even = ^data
//     10 -> 1
//     11 -> 0
//     data is masked to wls+5 bits before the reduction.
//   STOP: tx=1 for OVS ticks (stb=0), 2*OVS (stb=1, wls!=00),
//     or OVS*3/2 (stb=1, wls=00).
//   On the final STOP tick:
//     - fifo_empty=0: pop, load, go directly to START (no idle gap).
//     - otherwise: go to IDLE, sreg_empty=1.
//   set_break=1: tx forced 0 combinationally over the registered value.
//     The FSM keeps running, so the FIFO still drains. Release restores tx.
//   Config input changes mid-frame do not affect the current frame.
//   pop is never asserted when fifo_empty=1.
//   pop is never asserted in two consecutive clks.
// TESTING
//   1. wls=11, pen=1, eps=0, stb=0, din=0x45.
//      -> one pop; tx = 0,1,0,1,0,0,0,1,0,P=0,1.
//      -> each bit 16 ticks, 176 ticks total; then sreg_empty=1.
//   2. wls=00, pen=1, eps=1, stb=1, din=0xFF.
//      -> 5 ones, even parity P=1, 1.5 stop = 24 ticks.
//      -> 136 ticks total; bits 7:5 unused.
//   3. Two words 0xA5,0x3C queued, pen=0.
//      -> two pops 160 ticks apart.
//      -> the start bit of the 2nd frame follows the stop bit with no extra mark tick.
//   4. sticky_parity=1: eps=0 -> parity bit 1; eps=1 -> parity bit 0.
//      Check with din=0x00 and din=0xFF.
//   5. set_break=1 mid-frame -> tx=0 within 1 clk, FSM completes the frame.
//      set_break=0 while IDLE -> tx=1.
//   6. rst_n=0 during DATA -> tx=1, pop=0, sreg_empty=1 asynchronously.
//      After release, the next frame starts cleanly from IDLE.

Source files
------------

// File: rtl/uart_tx_if.sv
// TX FIFO read-side handshake between the transmit FIFO and the UART shifter.
// The FIFO is first-word-fall-through: din is valid whenever fifo_empty is low.
interface uart_tx_if;
  logic       fifo_empty;
  logic [7:0] din;
  logic       pop;

  modport master (output fifo_empty, output din, input pop);
  modport slave  (input fifo_empty, input din, output pop);
endinterface

// File: rtl/uart_tx_top.sv
// 16550-style UART transmitter: start / 5-8 data bits LSB-first / optional parity /
// 1, 1.5 or 2 stop bits, paced by a 16x oversample baud tick.
module uart_tx_top #(
  parameter int OVS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_pulse,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       sticky_parity,
  input  logic       set_break,
  uart_tx_if.slave   fifo,
  output logic       tx,
  output logic       sreg_empty
);

  localparam int CNT_W = $clog2(2 * OVS);
  localparam logic [CNT_W-1:0] LAST_BIT_TICK   = CNT_W'(OVS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP2_TICK = CNT_W'(2 * OVS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP15_TICK = CNT_W'(OVS * 3 / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] tick_cnt;
  logic [CNT_W-1:0] tick_max;
  logic [2:0]       bit_cnt;
  logic [2:0]       last_bit;
  logic [7:0]       shreg;
  logic [1:0]       wls_q;
  logic             stb_q;
  logic             pen_q;
  logic             par_q;
  logic             tx_q;
  logic             load;
  logic             tick_last;

  // Parity over the word masked to its configured length; sticky forces a constant.
  function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] w,
                                      input logic sticky, input logic even);
    logic [7:0] mask;
    logic       x;
    mask = 8'hFF >> (2'd3 - w);
    x    = ^(d & mask);
    case ({sticky, even})
      2'b00:   parity_bit = ~x;
      2'b01:   parity_bit = x;
      2'b10:   parity_bit = 1'b1;
      default: parity_bit = 1'b0;
    endcase
  endfunction

  always_comb begin
    tick_max = LAST_BIT_TICK;
    if (state == STOP && stb_q)
      tick_max = (wls_q == 2'b00) ? LAST_STOP15_TICK : LAST_STOP2_TICK;
  end

  assign last_bit  = 3'd4 + {1'b0, wls_q};
  assign tick_last = baud_pulse && (tick_cnt == tick_max);

  always_comb begin
    state_n = state;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (baud_pulse && !fifo.fifo_empty) begin
          load    = 1'b1;
          state_n = START;
        end
      end
      START: if (tick_last) state_n = DATA;
      DATA: begin
        if (tick_last && bit_cnt == last_bit)
          state_n = pen_q ? PARITY : STOP;
      end
      PARITY: if (tick_last) state_n = STOP;
      STOP: begin
        if (tick_last) begin
          if (!fifo.fifo_empty) begin
            load    = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Gating with rst_n keeps pop low while reset is held, whatever the inputs do.
  assign fifo.pop = load & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      tx_q       <= 1'b1;
      sreg_empty <= 1'b1;
    end else begin
      state <= state_n;
      if (load || tick_last)
        tick_cnt <= '0;
      else if (baud_pulse && state != IDLE)
        tick_cnt <= tick_cnt + 1'b1;

      if (load)
        bit_cnt <= '0;
      else if (state == DATA && tick_last)
        bit_cnt <= bit_cnt + 1'b1;

      if (load) begin
        tx_q       <= 1'b0;
        sreg_empty <= 1'b0;
      end else if (tick_last) begin
        case (state)
          START:  tx_q <= shreg[0];
          DATA:   tx_q <= (bit_cnt == last_bit) ? (pen_q ? par_q : 1'b1) : shreg[0];
          PARITY: tx_q <= 1'b1;
          STOP: begin
            tx_q       <= 1'b1;
            sreg_empty <= 1'b1;
          end
          default: tx_q <= 1'b1;
        endcase
      end
    end
  end

  // Frame word and configuration are frozen at load; shreg[0] is always the next bit to send.
  always_ff @(posedge clk) begin
    if (load) begin
      shreg <= fifo.din;
      wls_q <= wls;
      stb_q <= stb;
      pen_q <= pen;
      par_q <= parity_bit(fifo.din, wls, sticky_parity, eps);
    end else if (tick_last && (state == START || state == DATA)) begin
      shreg <= shreg >> 1;
    end
  end

  assign tx = tx_q & ~set_break;

endmodule

// File: tb/tb_uart_tx_top.sv
// Scoreboard bench for uart_tx_top: stimulus queues expected frames, a monitor
// samples tx once per baud tick from each pop and compares bit by bit.
module tb_uart_tx_top;
  localparam int OVS = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_pulse = 1'b0;
  logic [1:0] wls = 2'd3;
  logic       stb = 1'b0;
  logic       pen = 1'b0;
  logic       eps = 1'b0;
  logic       sticky_parity = 1'b0;
  logic       set_break = 1'b0;
  logic       tx;
  logic       sreg_empty;

  uart_tx_if fif ();

  uart_tx_top #(.OVS(OVS)) dut (
    .clk(clk), .rst_n(rst_n), .baud_pulse(baud_pulse), .wls(wls), .stb(stb),
    .pen(pen), .eps(eps), .sticky_parity(sticky_parity), .set_break(set_break),
    .fifo(fif), .tx(tx), .sreg_empty(sreg_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] bits;
    int          nb;
    int          stop_len;
    bit          b2b;
    bit          brk;
    bit          abort;
  } frame_t;

  typedef struct {
    logic [7:0] din;
    logic [1:0] wls;
    bit         pen, eps, sticky, stb;
    logic       par;
    int         stop_len;
  } vec_t;

  frame_t     exp_q[$];
  logic [7:0] fq[$];
  int         checks = 0;
  int         errors = 0;
  int         frames_done = 0;
  logic       prev_pop = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic frame_t mk(input logic [7:0] din, input int wl, input bit p_en,
                                input logic p, input int stop_len, input bit b2b,
                                input bit brk, input bit abort);
    frame_t f;
    int n;
    f.bits = '0;
    n = 1;
    for (int i = 0; i < wl; i++) begin
      f.bits[n] = din[i];
      n++;
    end
    if (p_en) begin
      f.bits[n] = p;
      n++;
    end
    f.bits[n] = 1'b1;
    f.nb = n + 1;
    f.stop_len = stop_len;
    f.b2b = b2b;
    f.brk = brk;
    f.abort = abort;
    return f;
  endfunction

  // 1-clk-wide baud tick every second clock.
  initial forever begin
    @(posedge clk);
    #1 baud_pulse = ~baud_pulse;
  end

  // First-word-fall-through FIFO model.
  initial begin
    logic       p;
    logic [7:0] tmp;
    fif.fifo_empty = 1'b1;
    fif.din = 8'h00;
    forever begin
      @(negedge clk);
      p = fif.pop;
      @(posedge clk);
      #1;
      if (p && fq.size() > 0) tmp = fq.pop_front();
      fif.fifo_empty = (fq.size() == 0);
      fif.din = (fq.size() > 0) ? fq[0] : 8'h00;
    end
  end

  always @(negedge clk) begin
    if (fif.pop) begin
      chk("pop_while_empty", fif.fifo_empty, 1'b0);
      chk("pop_back_to_back", prev_pop, 1'b0);
    end
    prev_pop <= fif.pop;
  end

  task automatic next_tick();
    do @(negedge clk); while (!baud_pulse);
  endtask

  task automatic check_frame(input frame_t d, output bit chained);
    bit   ok;
    bit   midpop;
    int   len;
    logic expb;
    chained = 1'b0;
    midpop = 1'b0;
    for (int b = 0; b < d.nb; b++) begin
      len = (b == d.nb - 1) ? d.stop_len : OVS;
      ok = 1'b1;
      expb = d.bits[b];
      for (int t = 0; t < len; t++) begin
        next_tick();
        if (!rst_n) begin
          chk("frame_aborted_unexpectedly", d.abort, 1'b1);
          frames_done++;
          return;
        end
        if (!d.brk && tx !== expb) ok = 1'b0;
        if (b == d.nb - 1 && t == len - 1) begin
          chained = fif.pop;
          chk("busy_on_last_tick", sreg_empty, 1'b0);
        end else if (fif.pop) begin
          midpop = 1'b1;
        end
      end
      if (!d.brk) chk($sformatf("bit%0d", b), ok, 1'b1);
    end
    chk("pop_mid_frame", midpop, 1'b0);
    chk("frame_not_aborted", d.abort, 1'b0);
    chk("back_to_back", chained, d.b2b);
    if (!chained) begin
      @(negedge clk);
      chk("idle_after_frame", sreg_empty, 1'b1);
    end
    frames_done++;
  endtask

  initial begin
    frame_t d;
    bit     ch;
    forever begin
      @(negedge clk);
      if (rst_n && baud_pulse && fif.pop) begin
        ch = 1'b1;
        while (ch) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pop", exp_q.size(), 1);
            ch = 1'b0;
          end else begin
            d = exp_q.pop_front();
            check_frame(d, ch);
          end
        end
      end
    end
  end

  task automatic wait_start();
    int c = 0;
    while (sreg_empty !== 1'b0 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("frame_start", sreg_empty, 1'b0);
  endtask

  task automatic wait_done(input int n);
    int c = 0;
    while (frames_done < n && c < 5000) begin
      @(negedge clk);
      c++;
    end
    chk("frames_done", frames_done, n);
  endtask

  task automatic set_cfg(input vec_t v);
    wls = v.wls; pen = v.pen; eps = v.eps; sticky_parity = v.sticky; stb = v.stb;
  endtask

  vec_t vecs[9];
  int   nf = 0;

  initial begin
    // din, wls, pen, eps, sticky, stb, parity, stop ticks
    vecs[0] = '{8'h45, 2'd3, 1, 0, 0, 0, 1'b0, 16};
    vecs[1] = '{8'hFF, 2'd0, 1, 1, 0, 1, 1'b1, 24};
    vecs[2] = '{8'h00, 2'd3, 1, 0, 1, 0, 1'b1, 16};
    vecs[3] = '{8'h00, 2'd3, 1, 1, 1, 0, 1'b0, 16};
    vecs[4] = '{8'hFF, 2'd3, 1, 0, 1, 0, 1'b1, 16};
    vecs[5] = '{8'hFF, 2'd3, 1, 1, 1, 0, 1'b0, 16};
    vecs[6] = '{8'h00, 2'd3, 1, 0, 1, 1, 1'b1, 32};
    vecs[7] = '{8'hC3, 2'd1, 1, 0, 0, 0, 1'b1, 16};
    vecs[8] = '{8'h80, 2'd2, 1, 1, 0, 0, 1'b0, 16};

    repeat (3) @(posedge clk);
    #2;
    chk("rst_tx", tx, 1'b1);
    chk("rst_pop", fif.pop, 1'b0);
    chk("rst_sreg_empty", sreg_empty, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Single frames; config is scrambled mid-frame and must not matter.
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      set_cfg(vecs[i]);
      exp_q.push_back(mk(vecs[i].din, int'(vecs[i].wls) + 5, vecs[i].pen, vecs[i].par,
                         vecs[i].stop_len, 1'b0, 1'b0, 1'b0));
      fq.push_back(vecs[i].din);
      wait_start();
      repeat (20) @(posedge clk);
      #1;
      wls = ~wls; pen = ~pen; eps = ~eps; sticky_parity = ~sticky_parity; stb = ~stb;
      nf++;
      wait_done(nf);
    end

    // Two queued words go out back to back.
    @(posedge clk);
    #1;
    wls = 2'd3; pen = 1'b0; eps = 1'b0; sticky_parity = 1'b0; stb = 1'b0;
    exp_q.push_back(mk(8'hA5, 8, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(8'h3C, 8, 1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b0));
    fq.push_back(8'hA5);
    fq.push_back(8'h3C);
    nf += 2;
    wait_done(nf);

    // Break mid-frame; the frame still completes underneath.
    @(posedge clk);
    #1;
    exp_q.push_back(mk(8'h55, 8, 1'b0, 1'b0, 16, 1'b0, 1'b1, 1'b0));
    fq.push_back(8'h55);
    wait_start();
    repeat (60) @(posedge clk);
    #1 set_break = 1'b1;
    @(negedge clk);
    chk("break_tx_low", tx, 1'b0);
    nf++;
    wait_done(nf);
    @(negedge clk);
    chk("break_idle_tx_low", tx, 1'b0);
    set_break = 1'b0;
    #1 chk("break_release_tx", tx, 1'b1);

    // Asynchronous reset during DATA of an all-zero word.
    @(posedge clk);
    #1;
    exp_q.push_back(mk(8'h00, 8, 1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b1));
    fq.push_back(8'h00);
    wait_start();
    repeat (50) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_tx", tx, 1'b1);
    chk("async_rst_pop", fif.pop, 1'b0);
    chk("async_rst_sreg_empty", sreg_empty, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    nf++;
    wait_done(nf);

    // Clean frame after reset: 0x3C has four ones, even parity 0.
    @(posedge clk);
    #1;
    wls = 2'd3; pen = 1'b1; eps = 1'b1; sticky_parity = 1'b0; stb = 1'b0;
    exp_q.push_back(mk(8'h3C, 8, 1'b1, 1'b0, 16, 1'b0, 1'b0, 1'b0));
    fq.push_back(8'h3C);
    nf++;
    wait_done(nf);

    repeat (10) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
